// File: rtl/div_clk_checker.sv
// Checker for an even clock divider running in the clk domain: edge strobes, level-length
// measurement against DIV_NUM/2, per-period error strobes, saturating error count and lock.
module div_clk_checker #(
  parameter int DIV_NUM   = 8,
  parameter int CNT_WIDTH = 16,
  parameter int LOCK_CNT  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 div_clk_in,
  input  logic                 en,
  output logic                 rise_pulse,
  output logic                 fall_pulse,
  output logic [CNT_WIDTH-1:0] high_len,
  output logic [CNT_WIDTH-1:0] low_len,
  output logic                 meas_valid,
  output logic                 period_err,
  output logic                 locked,
  output logic [7:0]           err_cnt
);

  localparam int GOOD_W = $clog2(LOCK_CNT + 1);

  localparam logic [CNT_WIDTH-1:0] HALF_LEN    = CNT_WIDTH'(DIV_NUM / 2);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LEN = CNT_WIDTH'(DIV_NUM);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX     = {CNT_WIDTH{1'b1}};
  localparam logic [GOOD_W-1:0]    GOOD_MAX    = GOOD_W'(LOCK_CNT);
  localparam logic [GOOD_W-1:0]    GOOD_ONE    = GOOD_W'(1);

  // Handshake: none. meas_valid and period_err are single-cycle strobes with no back-pressure;
  // high_len/low_len are stable from a meas_valid until the next falling/rising edge in TRACK.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEEK  = 2'd1,
    TRACK = 2'd2
  } state_t;

  state_t               state;
  logic                 div_q;
  logic [CNT_WIDTH-1:0] run_cnt;
  logic [GOOD_W-1:0]    good_cnt;

  logic                 edge_seen;
  logic                 rise_seen;
  logic                 fall_seen;
  logic                 timeout;
  logic                 period_good;
  logic [CNT_WIDTH-1:0] run_next;
  logic [GOOD_W-1:0]    good_next;
  logic [7:0]           err_next;

  // run_cnt at an edge is the length of the level that just ended.
  always_comb begin
    edge_seen   = div_clk_in ^ div_q;
    rise_seen   = div_clk_in & ~div_q;
    fall_seen   = ~div_clk_in & div_q;
    timeout     = ~edge_seen & (run_cnt == TIMEOUT_LEN);
    period_good = (high_len == HALF_LEN) && (run_cnt == HALF_LEN);
    run_next    = edge_seen ? CNT_ONE : ((run_cnt == CNT_MAX) ? run_cnt : run_cnt + CNT_ONE);
    good_next   = (good_cnt == GOOD_MAX) ? good_cnt : good_cnt + GOOD_ONE;
    err_next    = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      div_q      <= 1'b0;
      run_cnt    <= '0;
      good_cnt   <= '0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      high_len   <= '0;
      low_len    <= '0;
      meas_valid <= 1'b0;
      period_err <= 1'b0;
      locked     <= 1'b0;
      err_cnt    <= 8'd0;
    end else begin
      div_q      <= div_clk_in;
      run_cnt    <= run_next;
      rise_pulse <= rise_seen;
      fall_pulse <= fall_seen;
      meas_valid <= 1'b0;
      period_err <= 1'b0;

      // Disable overrides everything, including an edge landing in the same cycle.
      if (!en) begin
        state    <= IDLE;
        locked   <= 1'b0;
        good_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            locked   <= 1'b0;
            good_cnt <= '0;
            state    <= SEEK;
          end
          SEEK: begin
            if (rise_seen) state <= TRACK;
          end
          TRACK: begin
            if (fall_seen) begin
              high_len <= run_cnt;
            end else if (rise_seen) begin
              // An edge that coincides with run_cnt==DIV_NUM is judged as a period, not a timeout.
              low_len    <= run_cnt;
              meas_valid <= 1'b1;
              if (period_good) begin
                good_cnt <= good_next;
                locked   <= (good_next == GOOD_MAX);
              end else begin
                period_err <= 1'b1;
                err_cnt    <= err_next;
                good_cnt   <= '0;
                locked     <= 1'b0;
              end
            end else if (timeout) begin
              period_err <= 1'b1;
              err_cnt    <= err_next;
              good_cnt   <= '0;
              locked     <= 1'b0;
              state      <= SEEK;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // A rise always needs a fall in between, so measurement strobes can never repeat back to back.
  meas_valid_single: assert property (@(posedge clk) disable iff (!rst_n)
    meas_valid |=> !meas_valid);

  period_err_single: assert property (@(posedge clk) disable iff (!rst_n)
    period_err |=> !period_err);

  period_err_source: assert property (@(posedge clk) disable iff (!rst_n)
    period_err |-> (meas_valid || state == SEEK));

endmodule

// File: tb/tb_div_clk_checker.sv
// Bench for div_clk_checker: directed scenarios plus random waveforms, checked against a
// timestamp-based reference model and a measurement scoreboard.
module tb_div_clk_checker;

  localparam int DIV_NUM   = 8;
  localparam int CNT_WIDTH = 16;
  localparam int LOCK_CNT  = 4;
  localparam int HALF      = DIV_NUM / 2;
  localparam int VW        = 5 + 8 + 2 * CNT_WIDTH;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 div_clk_in = 1'b0;
  logic                 en = 1'b0;
  logic                 rise_pulse;
  logic                 fall_pulse;
  logic [CNT_WIDTH-1:0] high_len;
  logic [CNT_WIDTH-1:0] low_len;
  logic                 meas_valid;
  logic                 period_err;
  logic                 locked;
  logic [7:0]           err_cnt;

  div_clk_checker #(
    .DIV_NUM(DIV_NUM), .CNT_WIDTH(CNT_WIDTH), .LOCK_CNT(LOCK_CNT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .div_clk_in(div_clk_in), .en(en),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .high_len(high_len), .low_len(low_len),
    .meas_valid(meas_valid), .period_err(period_err),
    .locked(locked), .err_cnt(err_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at t=%0t", $time);
    $fatal(1);
  end

  int checks   = 0;
  int failures = 0;
  int t        = 0;
  bit mon_on   = 1'b0;

  // ---------------- reference model ----------------
  // Modes: 0 disabled, 1 waiting for a rising edge, 2 measuring periods.
  int m_mode      = 0;
  int m_last_edge = 0;
  bit m_prev      = 1'b0;
  int m_hl        = 0;
  int m_ll        = 0;
  int m_good      = 0;
  int m_err       = 0;
  bit e_rise = 1'b0, e_fall = 1'b0, e_mv = 1'b0, e_pe = 1'b0, e_lock = 1'b0;

  logic [2*CNT_WIDTH:0] exp_q[$];

  wire  [VW-1:0] dut_vec = {rise_pulse, fall_pulse, meas_valid, period_err, locked,
                            err_cnt, high_len, low_len};
  wire  [VW-1:0] exp_vec = {e_rise, e_fall, e_mv, e_pe, e_lock, 8'(m_err),
                            CNT_WIDTH'(m_hl), CNT_WIDTH'(m_ll)};

  task automatic model_clock(input bit d, input bit e, input bit r);
    int ended;
    bit rise;
    bit fall;
    if (!r) begin
      m_prev = 1'b0; m_last_edge = t + 1; m_mode = 0;
      m_hl = 0; m_ll = 0; m_good = 0; m_err = 0;
      e_rise = 0; e_fall = 0; e_mv = 0; e_pe = 0; e_lock = 0;
    end else begin
      ended = t - m_last_edge;
      if (ended > 65535) ended = 65535;
      rise = d && !m_prev;
      fall = !d && m_prev;
      e_rise = rise; e_fall = fall; e_mv = 0; e_pe = 0;
      if (!e || m_mode == 0) begin
        m_mode = e ? 1 : 0;
        m_good = 0;
        e_lock = 0;
      end else if (m_mode == 1) begin
        if (rise) m_mode = 2;
      end else if (fall) begin
        m_hl = ended;
      end else if (rise) begin
        m_ll = ended;
        e_mv = 1;
        if (m_hl == HALF && m_ll == HALF) begin
          m_good = (m_good < LOCK_CNT) ? m_good + 1 : LOCK_CNT;
        end else begin
          e_pe = 1;
          m_good = 0;
          if (m_err < 255) m_err++;
        end
        e_lock = (m_good == LOCK_CNT);
        exp_q.push_back({e_pe, CNT_WIDTH'(m_hl), CNT_WIDTH'(m_ll)});
      end else if (ended == DIV_NUM) begin
        e_pe = 1;
        m_good = 0;
        e_lock = 0;
        m_mode = 1;
        if (m_err < 255) m_err++;
      end
      if (rise || fall) m_last_edge = t;
      m_prev = d;
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [2*CNT_WIDTH:0] want;
    if (mon_on) begin
      checks++;
      if (dut_vec !== exp_vec) begin
        failures++;
        $display("FAIL cycle_compare t=%0d got=%h expected=%h", t, dut_vec, exp_vec);
      end
      if (meas_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL scoreboard t=%0d got meas hl=%0d ll=%0d expected no measurement",
                   t, high_len, low_len);
        end else begin
          want = exp_q.pop_front();
          if ({period_err, high_len, low_len} !== want) begin
            failures++;
            $display("FAIL scoreboard t=%0d got pe=%0b hl=%0d ll=%0d expected pe=%0b hl=%0d ll=%0d",
                     t, period_err, high_len, low_len, want[2*CNT_WIDTH],
                     want[2*CNT_WIDTH-1:CNT_WIDTH], want[CNT_WIDTH-1:0]);
          end
        end
      end
    end
  end

  // ---------------- driver / observation ----------------
  int rise_t[$], fall_t[$], mv_t[$], pe_t[$];
  int mv_hl[$], mv_ll[$], mv_err[$];
  bit mv_pe[$], mv_lock[$];
  int last_fall_t = 0;

  task automatic clear_obs();
    rise_t.delete(); fall_t.delete(); mv_t.delete(); pe_t.delete();
    mv_hl.delete(); mv_ll.delete(); mv_err.delete(); mv_pe.delete(); mv_lock.delete();
  endtask

  task automatic step(input bit d, input bit e);
    div_clk_in = d;
    en = e;
    @(posedge clk);
    t++;
    model_clock(d, e, rst_n);
    #1;
    if (rise_pulse === 1'b1) rise_t.push_back(t);
    if (fall_pulse === 1'b1) begin fall_t.push_back(t); last_fall_t = t; end
    if (period_err === 1'b1) pe_t.push_back(t);
    if (meas_valid === 1'b1) begin
      mv_t.push_back(t); mv_hl.push_back(int'(high_len)); mv_ll.push_back(int'(low_len));
      mv_err.push_back(int'(err_cnt)); mv_pe.push_back(period_err); mv_lock.push_back(locked);
    end
  endtask

  task automatic level(input bit v, input int n, input bit e);
    repeat (n) step(v, e);
  endtask

  task automatic wave(input int h, input int l, input int n, input bit e);
    repeat (n) begin
      level(1'b1, h, e);
      level(1'b0, l, e);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    mon_on = 1'b1;
    checks++;
    if (dut_vec !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h expected=0", dut_vec);
    end
    step(1'b1, 1'b0);
    checks++;
    if (rise_pulse !== 1'b1) begin
      failures++;
      $display("FAIL rise_after_reset got=%b expected=1", rise_pulse);
    end
    step(1'b1, 1'b0);
    checks++;
    if (rise_pulse !== 1'b0) begin
      failures++;
      $display("FAIL rise_width got=%b expected=0", rise_pulse);
    end
  endtask

  task automatic test_even_divider();
    bit ok = 1'b1;
    int got_lock = 0;
    do_reset();
    clear_obs();
    level(1'b0, 3, 1'b1);
    wave(HALF, HALF, 6, 1'b1);
    if (rise_t.size() != 6 || fall_t.size() != 6) ok = 1'b0;
    for (int i = 0; i < rise_t.size() && i < fall_t.size(); i++) begin
      if (fall_t[i] - rise_t[i] != HALF) ok = 1'b0;
      if (i > 0 && rise_t[i] - rise_t[i-1] != DIV_NUM) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL strobe_spacing got rises=%0d falls=%0d (or bad spacing) expected 6/6 spaced %0d",
               rise_t.size(), fall_t.size(), HALF);
    end
    checks++;
    if (mv_t.size() != 5 || mv_t[0] != rise_t[1]) begin
      failures++;
      $display("FAIL first_meas got count=%0d expected 5 starting at second rise", mv_t.size());
    end
    checks++;
    if (mv_hl.size() == 0 || mv_hl[0] != HALF || mv_ll[0] != HALF || mv_pe[0] != 1'b0) begin
      failures++;
      $display("FAIL first_meas_value got meas count=%0d expected hl=%0d ll=%0d pe=0",
               mv_hl.size(), HALF, HALF);
    end
    foreach (mv_lock[i]) got_lock |= int'(mv_lock[i]) << i;
    checks++;
    if (got_lock != 'b11000) begin
      failures++;
      $display("FAIL lock_pattern got=%b expected=11000", got_lock);
    end
  endtask

  task automatic test_bad_period();
    int got_pe = 0;
    int got_lock = 0;
    clear_obs();
    wave(3, 5, 1, 1'b1);
    wave(HALF, HALF, 5, 1'b1);
    foreach (mv_pe[i]) got_pe |= int'(mv_pe[i]) << i;
    foreach (mv_lock[i]) got_lock |= int'(mv_lock[i]) << i;
    checks++;
    if (mv_t.size() != 6 || got_pe != 'b000010 || got_lock != 'b100001) begin
      failures++;
      $display("FAIL bad_period_flags got n=%0d pe=%b lock=%b expected n=6 pe=000010 lock=100001",
               mv_t.size(), got_pe, got_lock);
    end
    checks++;
    if (mv_t.size() < 2 || mv_hl[1] != 3 || mv_ll[1] != 5 || mv_err[1] != 1) begin
      failures++;
      $display("FAIL bad_period_value got n=%0d expected hl=3 ll=5 err_cnt=1", mv_t.size());
    end
  endtask

  task automatic test_timeout();
    int f0 = last_fall_t;
    clear_obs();
    level(1'b0, 20, 1'b1);
    checks++;
    if (pe_t.size() != 1 || pe_t[0] - f0 != DIV_NUM || mv_t.size() != 0) begin
      failures++;
      $display("FAIL timeout_pulse got pe_count=%0d mv_count=%0d expected one period_err %0d cycles after fall, no meas",
               pe_t.size(), mv_t.size(), DIV_NUM);
    end
    checks++;
    if (err_cnt !== 8'd2 || locked !== 1'b0) begin
      failures++;
      $display("FAIL timeout_counts got err_cnt=%0d locked=%b expected 2/0", err_cnt, locked);
    end
    clear_obs();
    wave(HALF, HALF, 4, 1'b1);
    checks++;
    if (mv_t.size() != 3 || rise_t.size() != 4 || mv_t[0] != rise_t[1] || pe_t.size() != 0) begin
      failures++;
      $display("FAIL timeout_resume got mv_count=%0d pe_count=%0d expected 3 meas from second rise, no errors",
               mv_t.size(), pe_t.size());
    end
  endtask

  task automatic test_enable();
    int got_lock = 0;
    wave(HALF, HALF, 2, 1'b1);
    checks++;
    if (locked !== 1'b1) begin
      failures++;
      $display("FAIL enable_prelock got locked=%b expected 1", locked);
    end
    level(1'b1, 2, 1'b1);
    clear_obs();
    step(1'b1, 1'b0);
    checks++;
    if (locked !== 1'b0) begin
      failures++;
      $display("FAIL enable_drop_lock got locked=%b expected 0", locked);
    end
    level(1'b1, 1, 1'b0);
    level(1'b0, HALF, 1'b0);
    wave(HALF, HALF, 3, 1'b0);
    checks++;
    if (mv_t.size() != 0 || pe_t.size() != 0 || rise_t.size() != 3 || fall_t.size() != 4
        || err_cnt !== 8'd2) begin
      failures++;
      $display("FAIL enable_off got mv=%0d pe=%0d rises=%0d falls=%0d err_cnt=%0d expected 0/0/3/4/2",
               mv_t.size(), pe_t.size(), rise_t.size(), fall_t.size(), err_cnt);
    end
    clear_obs();
    level(1'b0, 2, 1'b1);
    wave(HALF, HALF, 6, 1'b1);
    foreach (mv_lock[i]) got_lock |= int'(mv_lock[i]) << i;
    checks++;
    if (mv_t.size() != 5 || got_lock != 'b11000 || pe_t.size() != 0 || err_cnt !== 8'd2) begin
      failures++;
      $display("FAIL enable_relock got n=%0d lock=%b pe=%0d err_cnt=%0d expected 5/11000/0/2",
               mv_t.size(), got_lock, pe_t.size(), err_cnt);
    end
  endtask

  task automatic test_reset_mid_track();
    int got_lock = 0;
    while (m_err < 7) wave(2, 6, 1, 1'b1);
    checks++;
    if (err_cnt !== 8'd7 || locked !== 1'b0) begin
      failures++;
      $display("FAIL pre_reset_counts got err_cnt=%0d locked=%b expected 7/0", err_cnt, locked);
    end
    rst_n = 1'b0;
    step(1'b0, 1'b1);
    rst_n = 1'b1;
    checks++;
    if (dut_vec !== '0) begin
      failures++;
      $display("FAIL mid_reset_outputs got=%h expected=0", dut_vec);
    end
    clear_obs();
    level(1'b0, 3, 1'b1);
    wave(HALF, HALF, 6, 1'b1);
    foreach (mv_lock[i]) got_lock |= int'(mv_lock[i]) << i;
    checks++;
    if (mv_t.size() != 5 || got_lock != 'b11000 || err_cnt !== 8'd0) begin
      failures++;
      $display("FAIL post_reset_lock got n=%0d lock=%b err_cnt=%0d expected 5/11000/0",
               mv_t.size(), got_lock, err_cnt);
    end
  endtask

  task automatic test_timeout_edge();
    do_reset();
    level(1'b0, 3, 1'b1);
    wave(HALF, HALF, 2, 1'b1);
    clear_obs();
    level(1'b1, DIV_NUM, 1'b1);
    level(1'b0, HALF, 1'b1);
    level(1'b1, 1, 1'b1);
    checks++;
    if (mv_t.size() != 2 || pe_t.size() != 1 || mv_hl[1] != DIV_NUM || mv_ll[1] != HALF
        || pe_t[0] != mv_t[1]) begin
      failures++;
      $display("FAIL timeout_edge got mv=%0d pe=%0d expected 2 meas, one error with hl=%0d ll=%0d",
               mv_t.size(), pe_t.size(), DIV_NUM, HALF);
    end
  endtask

  task automatic test_random();
    bit v;
    bit e;
    int n;
    for (int i = 0; i < 60; i++) begin
      v = ~div_clk_in;
      n = $urandom_range(1, 10);
      e = ($urandom_range(0, 7) != 0);
      for (int j = 0; j < n; j++) begin
        if ($urandom_range(0, 24) == 0) e = ~e;
        step(v, e);
      end
    end
    checks++;
    if (err_cnt !== 8'(m_err) || locked !== e_lock) begin
      failures++;
      $display("FAIL random_end got err_cnt=%0d locked=%b expected %0d/%b",
               err_cnt, locked, m_err, e_lock);
    end
  endtask

  task automatic test_saturation();
    int n_pe = 0;
    int n_lock = 0;
    do_reset();
    level(1'b0, 3, 1'b1);
    wave(HALF, HALF, 2, 1'b1);
    clear_obs();
    wave(2, 6, 300, 1'b1);
    level(1'b1, 1, 1'b1);
    foreach (mv_pe[i]) n_pe += int'(mv_pe[i]);
    foreach (mv_lock[i]) n_lock += int'(mv_lock[i]);
    checks++;
    if (err_cnt !== 8'd255 || n_pe != 300 || n_lock != 0 || mv_t.size() != 301) begin
      failures++;
      $display("FAIL saturation got err_cnt=%0d errors=%0d locks=%0d meas=%0d expected 255/300/0/301",
               err_cnt, n_pe, n_lock, mv_t.size());
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_even_divider();
    test_bad_period();
    test_timeout();
    test_enable();
    test_reset_mid_track();
    test_timeout_edge();
    test_random();
    test_saturation();
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d outstanding expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
